// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display-path arbiter.
package disp_arb_pkg;

    localparam int DAT_W = 16;
    localparam int PTR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after position `last`, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic             any,
    output logic [1:0]       idx
);

    logic [3:0] req_ext;
    logic [1:0] cand;

    always_comb begin
        req_ext = '0;
        req_ext[N_REQ-1:0] = req;
        any  = 1'b0;
        idx  = 2'd0;
        cand = 2'd0;
        // Scan from the farthest slot back to last+1 so the nearest hit overwrites the rest.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = 2'((int'(last) + k) % N_REQ);
            if (req_ext[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Time-shares the 4-digit display data/point path between requesters with a
// minimum visible hold per owner and a one-cycle break-before-make gap.
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          HOLD_MS  = 1000,
    parameter logic [15:0] IDLE_DAT = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce1ms,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  dat_in,
    input  logic [2*N_REQ-1:0]   ptr_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [15:0]          dat,
    output logic [1:0]           PTR,
    output logic [1:0]           owner,
    output logic                 busy
);

    localparam int CNT_W = clog2(HOLD_MS + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_MS - 1);

    // Handshake: req is a level held by a requester for as long as it wants the
    // display; gnt is one-hot and, once given, stays until the hold has expired and
    // either the owner lets go or someone else is waiting. Data is taken only while
    // both req[i] and gnt[i] are high.

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [15:0]      dat_n;
    logic [1:0]       ptr_n;
    logic [1:0]       owner_n;
    logic             busy_n;
    logic [1:0]       rr_ptr, rr_n;
    logic [CNT_W-1:0] hold_cnt, cnt_n;
    logic             expired, expired_n;

    logic [DAT_W-1:0] dat_arr [4];
    logic [PTR_W-1:0] ptr_arr [4];
    logic [3:0]       req_ext;
    logic [3:0]       own_oh;
    logic [3:0]       pick_oh;
    logic             pick_any;
    logic [1:0]       pick_idx;
    logic             owner_req;
    logic             others_req;
    logic             hold_done;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        if (i < N_REQ) begin : g_used
            assign dat_arr[i] = dat_in[DAT_W*i +: DAT_W];
            assign ptr_arr[i] = ptr_in[PTR_W*i +: PTR_W];
            assign req_ext[i] = req[i];
        end else begin : g_pad
            assign dat_arr[i] = '0;
            assign ptr_arr[i] = '0;
            assign req_ext[i] = 1'b0;
        end
    end

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req),
        .last (rr_ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign pick_oh    = 4'b0001 << pick_idx;
    assign own_oh     = 4'b0001 << owner;
    assign owner_req  = req_ext[owner];
    assign others_req = |(req_ext & ~own_oh);
    // The hold is over on the ce1ms that arrives with the counter already at zero,
    // and stays over (re-evaluated every cycle) until the owner is released.
    assign hold_done  = expired | (ce1ms & (hold_cnt == '0));

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        dat_n     = dat;
        ptr_n     = PTR;
        owner_n   = owner;
        busy_n    = busy;
        rr_n      = rr_ptr;
        cnt_n     = hold_cnt;
        expired_n = expired;
        case (state)
            ST_IDLE, ST_GAP: begin
                gnt_n  = '0;
                busy_n = 1'b0;
                if (pick_any) begin
                    state_n   = ST_OWN;
                    gnt_n     = pick_oh[N_REQ-1:0];
                    owner_n   = pick_idx;
                    busy_n    = 1'b1;
                    rr_n      = pick_idx;
                    cnt_n     = HOLD_LOAD;
                    expired_n = 1'b0;
                end else if (state == ST_GAP) begin
                    state_n = ST_IDLE;
                    dat_n   = IDLE_DAT;
                    ptr_n   = '0;
                end
            end
            ST_OWN: begin
                if (owner_req) begin
                    dat_n = dat_arr[owner];
                    ptr_n = ptr_arr[owner];
                end
                if (ce1ms && hold_cnt != '0) cnt_n = hold_cnt - 1'b1;
                if (ce1ms && hold_cnt == '0) expired_n = 1'b1;
                if (hold_done && (!owner_req || others_req)) begin
                    state_n = ST_GAP;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
                dat_n   = IDLE_DAT;
                ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            dat      <= IDLE_DAT;
            PTR      <= '0;
            owner    <= 2'd0;
            busy     <= 1'b0;
            rr_ptr   <= 2'(N_REQ - 1);
            hold_cnt <= '0;
            expired  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            dat      <= dat_n;
            PTR      <= ptr_n;
            owner    <= owner_n;
            busy     <= busy_n;
            rr_ptr   <= rr_n;
            hold_cnt <= cnt_n;
            expired  <= expired_n;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with N_REQ=4, HOLD_MS=3 and ce1ms every 10 cycles.
module tb_disp_arbiter;

    localparam int N_REQ   = 4;
    localparam int HOLD_MS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce1ms;
    logic [3:0]  req;
    logic [63:0] dat_in;
    logic [7:0]  ptr_in;
    logic [3:0]  gnt;
    logic [15:0] dat;
    logic [1:0]  PTR;
    logic [1:0]  owner;
    logic        busy;

    int         n_cmp = 0;
    int         n_err = 0;
    int         ce_cnt = 0;
    logic       ce_auto = 1'b0;
    int         ticks = 0;
    int         bad;
    logic [1:0] exp_q[$];
    logic [1:0] exp_own;
    logic [3:0] one_hot;

    disp_arbiter #(
        .N_REQ    (N_REQ),
        .HOLD_MS  (HOLD_MS),
        .IDLE_DAT (16'h0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce1ms  (ce1ms),
        .req    (req),
        .dat_in (dat_in),
        .ptr_in (ptr_in),
        .gnt    (gnt),
        .dat    (dat),
        .PTR    (PTR),
        .owner  (owner),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge; outputs are stable there and the
    // ce1ms value set here is the one the following rising edge sees.
    task automatic cyc();
        @(negedge clk);
        if (ce_auto) begin
            ce_cnt = (ce_cnt == 9) ? 0 : ce_cnt + 1;
            ce1ms  = (ce_cnt == 9);
        end else begin
            ce1ms = 1'b0;
        end
    endtask

    task automatic cyc_mon();
        cyc();
        if (gnt != 4'b0000 && ce1ms) ticks++;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        dat_in = '0;
        ptr_in = '0;
        ce1ms  = 1'b0;
        ce_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int prev_gnt;
        int gap;
        int grants;
        logic first;

        // Reset state and single-requester latency
        do_reset();
        check_val("rst_gnt", gnt, 4'b0000);
        check_val("rst_dat", dat, 16'h0000);
        check_val("rst_ptr", PTR, 2'd0);
        check_val("rst_owner", owner, 2'd0);
        check_val("rst_busy", busy, 1'b0);
        req = 4'b0100;
        dat_in[47:32] = 16'h1234;
        ptr_in[5:4]   = 2'd1;
        cyc();
        check_val("t1_gnt", gnt, 4'b0100);
        check_val("t1_owner", owner, 2'd2);
        check_val("t1_busy", busy, 1'b1);
        check_val("t1_dat_latency", dat, 16'h0000);
        cyc();
        check_val("t1_dat", dat, 16'h1234);
        check_val("t1_ptr", PTR, 2'd1);

        // All four requesting: order 0,1,2,3,0 with 3 ticks each and 1-cycle gaps
        do_reset();
        ce_auto = 1'b1;
        req = 4'b1111;
        dat_in = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        prev_gnt = 0;
        gap = 0;
        grants = 0;
        first = 1'b1;
        for (int c = 0; c < 400 && grants < 5; c++) begin
            cyc();
            if (gnt != 4'b0000) begin
                if (prev_gnt == 0) begin
                    if (!first) check_val("rr_gap_len", gap, 1);
                    first = 1'b0;
                    exp_own = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
                    one_hot = 4'b0001 << exp_own;
                    check_val("rr_grant", gnt, one_hot);
                    check_val("rr_owner", owner, exp_own);
                    ticks = 0;
                end
                if (ce1ms) ticks++;
            end else begin
                if (prev_gnt != 0) begin
                    check_val("rr_hold_ticks", ticks, 3);
                    grants++;
                    gap = 0;
                end
                gap++;
            end
            prev_gnt = int'(gnt);
        end
        check_val("rr_grants_done", grants, 5);

        // Lone owner keeps the display, then is preempted by req[3]
        do_reset();
        req = 4'b0010;
        cyc();
        check_val("solo_gnt", gnt, 4'b0010);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (gnt !== 4'b0010) bad++;
        end
        check_val("solo_hold_bad_cycles", bad, 0);
        req = 4'b1010;
        cyc();
        check_val("preempt_gap", gnt, 4'b0000);
        cyc();
        check_val("preempt_gnt", gnt, 4'b1000);
        check_val("preempt_owner", owner, 2'd3);

        // Owner drops its request: data freezes, grant held to the 3rd tick, then idle
        do_reset();
        req = 4'b0001;
        dat_in[15:0] = 16'h1000;
        ticks = 0;
        cyc_mon();
        for (int i = 0; i < 4; i++) begin
            dat_in[15:0] = 16'hA000 + 16'(i);
            cyc_mon();
        end
        dat_in[15:0] = 16'hBEEF;
        cyc_mon();
        req = 4'b0000;
        dat_in[15:0] = 16'hDEAD;
        cyc_mon();
        check_val("drop_dat_frozen", dat, 16'hBEEF);
        check_val("drop_gnt_held", gnt, 4'b0001);
        bad = 0;
        for (int c = 0; c < 100 && gnt != 4'b0000; c++) begin
            if (dat !== 16'hBEEF) bad++;
            cyc_mon();
        end
        check_val("drop_gnt_released", gnt, 4'b0000);
        check_val("drop_dat_bad_cycles", bad, 0);
        check_val("drop_hold_ticks", ticks, 3);
        check_val("drop_gap_dat", dat, 16'hBEEF);
        check_val("drop_gap_busy", busy, 1'b0);
        cyc();
        check_val("drop_idle_dat", dat, 16'h0000);
        check_val("drop_idle_ptr", PTR, 2'd0);

        // Asynchronous reset while owned
        do_reset();
        req = 4'b0100;
        dat_in[47:32] = 16'h1234;
        ptr_in[5:4]   = 2'd1;
        cyc();
        cyc();
        check_val("arst_pre_dat", dat, 16'h1234);
        #2 rst = 1'b1;
        #1;
        check_val("arst_gnt", gnt, 4'b0000);
        check_val("arst_dat", dat, 16'h0000);
        check_val("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        ce_cnt = 0;
        cyc();
        check_val("arst_rr_first", gnt, 4'b0001);
        check_val("arst_rr_owner", owner, 2'd0);

        // ce1ms coincident with the grant-load edge is ignored
        do_reset();
        for (int c = 0; c < 20 && !ce1ms; c++) cyc();
        req = 4'b0100;
        ticks = 0;
        cyc_mon();
        check_val("coinc_gnt", gnt, 4'b0100);
        check_val("coinc_cnt_after_load", dut.hold_cnt, 2);
        req = 4'b0000;
        for (int c = 0; c < 100 && gnt != 4'b0000; c++) cyc_mon();
        check_val("coinc_released", gnt, 4'b0000);
        check_val("coinc_hold_ticks", ticks, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the 4-digit 7-segment display path between up to 4 requesters (counter, UART monitor, key debug, etc.).
- Outputs 16-bit hex data and a 2-bit decimal-point pointer straight into the display block's `dat`/`PTR` inputs.
- Uses that block's `ce1ms` strobe as its time base to enforce a minimum visible hold per owner.
- Round-robin, break-before-make handover.

Parameters:
- N_REQ, 4, number of requesters, legal 2..4.
- HOLD_MS, 1000, minimum ownership time in ce1ms ticks, legal >= 1.
- IDLE_DAT, 16'h0000, value driven on dat while no owner.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ce1ms  in  1  1-cycle strobe every 1 ms from the display block.
- req  in  N_REQ  request per requester, level.
- dat_in  in  16*N_REQ  requester data, slice i = [16i+15:16i].
- ptr_in  in  2*N_REQ  requester point position, slice i = [2i+1:2i].
- gnt  out  N_REQ  one-hot grant, all zero when no owner.
- dat  out  16  to display data input.
- PTR  out  2  to display point input.
- owner  out  2  index of current/last owner.
- busy  out  1  high while in OWN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, gnt=0, dat=IDLE_DAT, PTR=0, owner=0, busy=0.
  - Hold counter=0.
  - RR pointer = N_REQ-1, so req[0] has top priority first.
- All outputs are registered.
- FSM states:
  - IDLE: no owner, dat=IDLE_DAT, PTR=0.
  - OWN: one owner granted.
  - GAP: one cycle, gnt=0, dat/PTR hold last value.
- IDLE -> OWN:
  - Trigger: any req bit high.
  - Winner = first set bit searching from RR pointer+1, wrapping modulo N_REQ.
  - Next cycle: gnt[w]=1, owner=w, busy=1, RR pointer=w, hold counter loaded HOLD_MS-1.
- OWN data path:
  - While req[owner]=1: dat/PTR register dat_in/ptr_in slice of owner each cycle (1-cycle latency).
  - If req[owner] falls: dat/PTR freeze at last sampled value. gnt stays asserted until hold expires.
- Hold counter:
  - Decrements on ce1ms when nonzero.
  - A ce1ms in the grant-load cycle is ignored (the load wins).
- Release decision, evaluated only when counter==0 in OWN:
  - req[owner]=0 -> GAP.
  - req[owner]=1 and some other req set -> GAP (preempt).
  - req[owner]=1 and no other req -> stay in OWN; counter stays 0, so the decision is re-evaluated every cycle.
- GAP:
  - gnt=0, busy=0.
  - Next cycle: if any req, grant the RR winner (the previous owner is considered last), as in IDLE -> OWN. Otherwise go to IDLE and load dat=IDLE_DAT, PTR=0.
- Simultaneous requests: resolved purely by RR order; never two gnt bits high.
- A req pulse shorter than 1 cycle, or one that falls before it is sampled in IDLE/GAP, is never granted.
- HOLD_MS=1: the owner keeps gnt for at least 1 ce1ms edge after grant.
- Reset mid-OWN: gnt drops asynchronously and the display goes to IDLE_DAT.

Decomposition:
- Package disp_arb_pkg:
  - State encodings ST_IDLE=2'd0, ST_OWN=2'd1, ST_GAP=2'd2.
  - Counter width function clog2.
  - Slice helper constants DAT_W=16, PTR_W=2.
- Sub-module rr_pick (combinational):
  - Inputs: req[N_REQ], last[1:0].
  - Outputs: any, idx[1:0].
  - Instantiated once; used from both IDLE and GAP.

Test Plan (N_REQ=4, HOLD_MS=3, ce1ms every 10 cycles):
- Reset, then req=4'b0100, dat_in[2]=16'h1234, ptr_in[2]=2'd1 -> 1 cycle later gnt=4'b0100, owner=2, busy=1; next cycle dat=16'h1234, PTR=1.
- req=4'b1111 from reset -> grant order 0,1,2,3,0. Each grant lasts exactly 3 ce1ms edges after load and is separated by 1 GAP cycle with gnt=0.
- Owner 1 alone, req[1] held 100 cycles -> gnt stays 4'b0010 throughout, no GAP. Raise req[3] -> gnt drops within 2 cycles, gnt=4'b1000 the cycle after GAP.
- Owner 0 drops req after 5 cycles with dat_in[0] last=16'hBEEF -> dat stays 16'hBEEF and gnt[0] stays until the 3rd ce1ms. Then GAP, IDLE, dat=16'h0000.
- Assert rst mid-OWN between clock edges -> gnt=0, dat=IDLE_DAT, busy=0 immediately. After release, req=4'b0011 -> req[0] wins first.
- Coincident ce1ms and grant-load cycle -> counter reads 2 after load, not 1. Owner still sees 3 further ce1ms edges.
